// File: rtl/sign_narrow_if.sv
// Stream bundle for sign_narrow: word input and narrowed-result output handshakes.
interface sign_narrow_if #(
    parameter int unsigned IN_W  = 32,
    parameter int unsigned OUT_W = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [IN_W-1:0]  in_data;
    logic             out_valid;
    logic             out_ready;
    logic [OUT_W-1:0] out_data;
    logic             out_ovf;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_ovf
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_ovf
    );
endinterface

// File: rtl/sign_narrow.sv
// Signed IN_W -> OUT_W narrowing stream stage with 2-entry output buffer and overflow status.
// Optional build macro SIGN_NARROW_SAT_EN: saturate overflowing words instead of wrapping.
module sign_narrow #(
    parameter int unsigned IN_W  = 32,
    parameter int unsigned OUT_W = 16,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    sign_narrow_if.slave     bus,
    input  logic             clr_status,
    output logic [CNT_W-1:0] ovf_count,
    output logic             ovf_sticky
);
    localparam int unsigned TOP_W = IN_W - OUT_W + 1;
    localparam int unsigned ENT_W = OUT_W + 1;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } occ_e;

    occ_e             occ_q, occ_d;
    logic [ENT_W-1:0] head_q, head_d;
    logic [ENT_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             sticky_q, sticky_d;

    logic [TOP_W-1:0] top_bits;
    logic             ovf;
    logic [OUT_W-1:0] narrowed;
    logic [ENT_W-1:0] new_ent;
    logic             push;
    logic             pop;

    // Fit check: bits above the output sign bit must replicate it.
    always_comb begin
        top_bits = bus.in_data[IN_W-1:OUT_W-1];
        ovf      = !((&top_bits) || (~|top_bits));
`ifdef SIGN_NARROW_SAT_EN
        if (ovf) begin
            narrowed = bus.in_data[IN_W-1] ? {1'b1, {(OUT_W-1){1'b0}}}
                                           : {1'b0, {(OUT_W-1){1'b1}}};
        end else begin
            narrowed = bus.in_data[OUT_W-1:0];
        end
`else
        narrowed = bus.in_data[OUT_W-1:0];
`endif
        new_ent = {ovf, narrowed};
    end

    assign bus.in_ready  = !rst && (occ_q != FULL);
    assign bus.out_valid = (occ_q != EMPTY);
    assign bus.out_ovf   = head_q[OUT_W];
    assign bus.out_data  = head_q[OUT_W-1:0];
    assign ovf_count     = cnt_q;
    assign ovf_sticky    = sticky_q;

    assign push = bus.in_valid && bus.in_ready;
    assign pop  = bus.out_valid && bus.out_ready;

    // Occupancy FSM; head is cleared whenever the buffer drains so outputs read 0.
    always_comb begin
        occ_d  = occ_q;
        head_d = head_q;
        tail_d = tail_q;
        case (occ_q)
            EMPTY: begin
                if (push) begin
                    head_d = new_ent;
                    occ_d  = ONE;
                end
            end
            ONE: begin
                if (push && pop) begin
                    head_d = new_ent;
                end else if (push) begin
                    tail_d = new_ent;
                    occ_d  = FULL;
                end else if (pop) begin
                    head_d = '0;
                    occ_d  = EMPTY;
                end
            end
            FULL: begin
                if (pop) begin
                    head_d = tail_q;
                    tail_d = '0;
                    occ_d  = ONE;
                end
            end
            default: begin
                occ_d  = EMPTY;
                head_d = '0;
                tail_d = '0;
            end
        endcase
    end

    // Status: a clear coinciding with an overflowing accept still records that event.
    always_comb begin
        cnt_d    = cnt_q;
        sticky_d = sticky_q;
        if (clr_status) begin
            cnt_d    = (push && ovf) ? CNT_W'(1) : '0;
            sticky_d = push && ovf;
        end else if (push && ovf) begin
            sticky_d = 1'b1;
            if (cnt_q != {CNT_W{1'b1}}) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            occ_q    <= EMPTY;
            head_q   <= '0;
            tail_q   <= '0;
            cnt_q    <= '0;
            sticky_q <= 1'b0;
        end else begin
            occ_q    <= occ_d;
            head_q   <= head_d;
            tail_q   <= tail_d;
            cnt_q    <= cnt_d;
            sticky_q <= sticky_d;
        end
    end
endmodule

// File: tb/tb_sign_narrow.sv
// Self-checking bench for sign_narrow: vector table, directed corner sequences, random traffic vs. queue model.
module tb_sign_narrow;
    localparam int unsigned IN_W  = 32;
    localparam int unsigned OUT_W = 16;
    localparam int unsigned CNT_W = 8;
    localparam int          CNT_MAX = (1 << CNT_W) - 1;

    logic             clk;
    logic             rst;
    logic             clr_status;
    logic [CNT_W-1:0] ovf_count;
    logic             ovf_sticky;

    sign_narrow_if #(.IN_W(IN_W), .OUT_W(OUT_W)) bus ();

    sign_narrow #(.IN_W(IN_W), .OUT_W(OUT_W), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .clr_status (clr_status),
        .ovf_count  (ovf_count),
        .ovf_sticky (ovf_sticky)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: FIFO of {ovf, value} plus status counters.
    logic [OUT_W:0]   mq[$];
    int               m_cnt = 0;
    bit               m_sticky = 1'b0;
    logic [OUT_W-1:0] popped[$];

    typedef struct {
        logic [IN_W-1:0]  din;
        logic [OUT_W-1:0] dout;
        logic             ovf;
        int               cnt;
    } vec_t;

    vec_t vecs[5];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Narrowing from the arithmetic rules: range test on the signed value.
    function automatic void ref_narrow(input logic [IN_W-1:0] d,
                                       output logic [OUT_W-1:0] o, output logic f);
        longint v, lo, hi;
        v  = longint'($signed(d));
        hi = (longint'(1) <<< (OUT_W - 1)) - 1;
        lo = -hi - 1;
        f  = (v > hi) || (v < lo);
        o  = OUT_W'(v);
`ifdef SIGN_NARROW_SAT_EN
        if (v > hi) o = OUT_W'(hi);
        else if (v < lo) o = OUT_W'(lo);
`endif
    endfunction

    // One clock: drive, check pre-edge outputs against the model, advance model after the edge.
    task automatic cycle(input logic v, input logic [IN_W-1:0] d, input logic ordy,
                         input logic clr, input logic r);
        logic [OUT_W-1:0] rd;
        logic             rovf;
        logic             acc, pp;
        logic [OUT_W-1:0] exp_d;
        logic             exp_o;
        rst = r; bus.in_valid = v; bus.in_data = d; bus.out_ready = ordy; clr_status = clr;
        #1;
        exp_d = (mq.size() != 0) ? mq[0][OUT_W-1:0] : '0;
        exp_o = (mq.size() != 0) ? mq[0][OUT_W] : 1'b0;
        chk("in_ready",   64'(bus.in_ready),  64'(!r && mq.size() < 2));
        chk("out_valid",  64'(bus.out_valid), 64'(mq.size() != 0));
        chk("out_data",   64'(bus.out_data),  64'(exp_d));
        chk("out_ovf",    64'(bus.out_ovf),   64'(exp_o));
        chk("ovf_count",  64'(ovf_count),     64'(m_cnt));
        chk("ovf_sticky", 64'(ovf_sticky),    64'(m_sticky));
        if (!r && bus.out_valid && ordy) popped.push_back(bus.out_data);
        ref_narrow(d, rd, rovf);
        acc = v && !r && (mq.size() < 2);
        pp  = (mq.size() != 0) && ordy;
        @(posedge clk);
        #1;
        if (r) begin
            mq.delete();
            m_cnt = 0;
            m_sticky = 1'b0;
        end else begin
            if (pp) void'(mq.pop_front());
            if (acc) mq.push_back({rovf, rd});
            if (clr) begin
                m_cnt    = (acc && rovf) ? 1 : 0;
                m_sticky = acc && rovf;
            end else if (acc && rovf) begin
                m_sticky = 1'b1;
                if (m_cnt < CNT_MAX) m_cnt++;
            end
        end
    endtask

    initial begin
        logic [IN_W-1:0] bnd[6];
        logic [IN_W-1:0] d;
        int              s;

        vecs[0] = '{32'h0000_000F, 16'h000F, 1'b0, 0};
        vecs[1] = '{32'h0000_007F, 16'h007F, 1'b0, 0};
        vecs[2] = '{32'hFFFF_8000, 16'h8000, 1'b0, 0};
`ifdef SIGN_NARROW_SAT_EN
        vecs[3] = '{32'h0000_8000, 16'h7FFF, 1'b1, 1};
        vecs[4] = '{32'hFFFF_7FFF, 16'h8000, 1'b1, 2};
`else
        vecs[3] = '{32'h0000_8000, 16'h8000, 1'b1, 1};
        vecs[4] = '{32'hFFFF_7FFF, 16'h7FFF, 1'b1, 2};
`endif
        bnd[0] = 32'h0000_7FFF; bnd[1] = 32'h0000_8000; bnd[2] = 32'hFFFF_8000;
        bnd[3] = 32'hFFFF_7FFF; bnd[4] = 32'h0000_0000; bnd[5] = 32'hFFFF_FFFF;

        rst = 1'b1; bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ready = 1'b0; clr_status = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_in_ready",  64'(bus.in_ready),  64'(0));
        chk("rst_out_valid", 64'(bus.out_valid), 64'(0));
        chk("rst_out_data",  64'(bus.out_data),  64'(0));
        chk("rst_ovf_count", 64'(ovf_count),     64'(0));
        cycle(1'b0, '0, 1'b0, 1'b0, 1'b1);
        rst = 1'b0;
        #1;
        chk("post_rst_in_ready", 64'(bus.in_ready), 64'(1));

        // Vector table: each word visible one edge after acceptance.
        for (int i = 0; i < 5; i++) begin
            cycle(1'b1, vecs[i].din, 1'b1, 1'b0, 1'b0);
            chk($sformatf("vec%0d_valid", i), 64'(bus.out_valid), 64'(1));
            chk($sformatf("vec%0d_data", i),  64'(bus.out_data),  64'(vecs[i].dout));
            chk($sformatf("vec%0d_ovf", i),   64'(bus.out_ovf),   64'(vecs[i].ovf));
            chk($sformatf("vec%0d_cnt", i),   64'(ovf_count),     64'(vecs[i].cnt));
        end
        cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);
        chk("vec_sticky", 64'(ovf_sticky), 64'(1));

        // Backpressure: third word held until the first pop.
        popped.delete();
        cycle(1'b1, 32'h1, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 32'h2, 1'b0, 1'b0, 1'b0);
        chk("bp_in_ready_low", 64'(bus.in_ready), 64'(0));
        cycle(1'b1, 32'h3, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 32'h3, 1'b1, 1'b0, 1'b0);
        cycle(1'b1, 32'h3, 1'b1, 1'b0, 1'b0);
        cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);
        cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);
        chk("bp_pop_count", 64'(popped.size()), 64'(3));
        for (int i = 0; i < 3 && i < popped.size(); i++)
            chk($sformatf("bp_order%0d", i), 64'(popped[i]), 64'(i + 1));

        // Counter saturation then clear.
        cycle(1'b0, '0, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 300; i++) cycle(1'b1, 32'h0001_0000, 1'b1, 1'b0, 1'b0);
        chk("sat_count", 64'(ovf_count), 64'(255));
        cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);
        chk("sat_hold", 64'(ovf_count), 64'(255));
        cycle(1'b0, '0, 1'b1, 1'b1, 1'b0);
        chk("clr_count",  64'(ovf_count),  64'(0));
        chk("clr_sticky", 64'(ovf_sticky), 64'(0));

        // Clear colliding with an overflowing accept.
        for (int i = 0; i < 5; i++) cycle(1'b1, 32'h0001_0000, 1'b1, 1'b0, 1'b0);
        chk("coll_pre", 64'(ovf_count), 64'(5));
        cycle(1'b1, 32'h0001_0000, 1'b1, 1'b1, 1'b0);
        chk("coll_count",  64'(ovf_count),  64'(1));
        chk("coll_sticky", 64'(ovf_sticky), 64'(1));
        cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);

        // Reset with the buffer full and status nonzero.
        cycle(1'b1, 32'h0002_0000, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 32'h0002_0000, 1'b0, 1'b0, 1'b0);
        chk("full_in_ready", 64'(bus.in_ready), 64'(0));
        cycle(1'b0, '0, 1'b0, 1'b0, 1'b1);
        chk("mrst_in_ready",  64'(bus.in_ready),  64'(0));
        chk("mrst_out_valid", 64'(bus.out_valid), 64'(0));
        chk("mrst_out_data",  64'(bus.out_data),  64'(0));
        chk("mrst_count",     64'(ovf_count),     64'(0));
        chk("mrst_sticky",    64'(ovf_sticky),    64'(0));
        rst = 1'b0;
        #1;
        chk("mrst_in_ready_after", 64'(bus.in_ready), 64'(1));

        // Random traffic against the model.
        for (int i = 0; i < 2000; i++) begin
            case ($urandom_range(0, 3))
                0: begin
                    s = int'($urandom_range(0, 65535)) - 32768;
                    d = IN_W'(s);
                end
                1: d = bnd[$urandom_range(0, 5)];
                default: d = IN_W'($urandom);
            endcase
            cycle(($urandom_range(0, 3) != 0), d, ($urandom_range(0, 2) != 0),
                  ($urandom_range(0, 29) == 0), ($urandom_range(0, 199) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
